// File: rtl/ram_pin_link.sv
// Serial RAM link: frames a request address onto narrow address pins,
// waits a fixed latency, then collects one or more words from narrow data pins.
module ram_pin_link #(
    parameter int RAM_PINS  = 4,
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16,
    parameter int LATENCY   = 3,
    parameter int LEN_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [LEN_BITS-1:0]  req_len,
    output logic                 rsp_valid,
    output logic [DATA_BITS-1:0] rsp_data,
    output logic                 rsp_last,
    output logic [RAM_PINS-1:0]  addr_pins,
    input  logic [RAM_PINS-1:0]  data_pins
);

    localparam int NA     = ADDR_BITS / RAM_PINS;
    localparam int ND     = DATA_BITS / RAM_PINS;
    localparam int MAX_AD = (NA > ND) ? NA : ND;
    localparam int MAXC   = (MAX_AD > LATENCY) ? MAX_AD : LATENCY;
    localparam int CNT_W  = $clog2(MAXC + 1);

    localparam logic [CNT_W-1:0] ZERO_C     = CNT_W'(0);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
    localparam logic [CNT_W-1:0] NA_C       = CNT_W'(NA);
    localparam logic [CNT_W-1:0] WAIT_END_C = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] ND_END_C   = CNT_W'(ND - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ADDR  = 3'd2,
        WAIT  = 3'd3,
        DATA  = 3'd4
    } state_t;

    state_t                 state_q;
    logic                   req_ready_q;
    logic                   rsp_valid_q;
    logic                   rsp_last_q;
    logic [DATA_BITS-1:0]   rsp_data_q;
    logic [RAM_PINS-1:0]    addr_pins_q;
    logic [ADDR_BITS-1:0]   addr_sh_q;
    logic [DATA_BITS-1:0]   data_sh_q;
    logic [LEN_BITS-1:0]    len_q;
    logic [LEN_BITS-1:0]    word_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DATA_BITS-1:0]   data_sh_d;
    logic [DATA_BITS+RAM_PINS-1:0] data_cat_s;

    // Incoming nibble enters at the top so the first (LSB) nibble ends up lowest.
    always_comb begin
        data_cat_s = {data_pins, data_sh_q};
        data_sh_d  = data_cat_s[DATA_BITS+RAM_PINS-1:RAM_PINS];
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= {DATA_BITS{1'b0}};
            addr_pins_q <= {RAM_PINS{1'b0}};
            addr_sh_q   <= {ADDR_BITS{1'b0}};
            data_sh_q   <= {DATA_BITS{1'b0}};
            len_q       <= {LEN_BITS{1'b0}};
            word_q      <= {LEN_BITS{1'b0}};
            cnt_q       <= ZERO_C;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_sh_q   <= req_addr;
                        len_q       <= req_len;
                        word_q      <= {LEN_BITS{1'b0}};
                        addr_pins_q <= {RAM_PINS{1'b1}};
                        req_ready_q <= 1'b0;
                        state_q     <= START;
                    end
                end
                START: begin
                    addr_pins_q <= addr_sh_q[RAM_PINS-1:0];
                    addr_sh_q   <= addr_sh_q >> RAM_PINS;
                    cnt_q       <= ONE_C;
                    state_q     <= ADDR;
                end
                ADDR: begin
                    // cnt_q = nibbles already placed on the pins
                    if (cnt_q == NA_C) begin
                        addr_pins_q <= {RAM_PINS{1'b0}};
                        if (LATENCY == 1) begin
                            cnt_q   <= ZERO_C;
                            state_q <= DATA;
                        end else begin
                            cnt_q   <= ONE_C;
                            state_q <= WAIT;
                        end
                    end else begin
                        addr_pins_q <= addr_sh_q[RAM_PINS-1:0];
                        addr_sh_q   <= addr_sh_q >> RAM_PINS;
                        cnt_q       <= cnt_q + ONE_C;
                    end
                end
                WAIT: begin
                    if (cnt_q == WAIT_END_C) begin
                        cnt_q   <= ZERO_C;
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + ONE_C;
                    end
                end
                DATA: begin
                    data_sh_q <= data_sh_d;
                    if (cnt_q == ND_END_C) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= data_sh_d;
                        cnt_q       <= ZERO_C;
                        if (word_q == len_q) begin
                            rsp_last_q  <= 1'b1;
                            req_ready_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            word_q <= word_q + LEN_BITS'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + ONE_C;
                    end
                end
                default: begin
                    addr_pins_q <= {RAM_PINS{1'b0}};
                    req_ready_q <= 1'b1;
                    cnt_q       <= ZERO_C;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_data  = rsp_data_q;
    assign addr_pins = addr_pins_q;

endmodule

// File: tb/tb_ram_pin_link.sv
// Directed bench for ram_pin_link: cycle-by-cycle expectations for single reads,
// bursts, back-to-back requests, mid-transaction reset and input changes after acceptance.
module tb_ram_pin_link;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [1:0]  req_len;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_last;
    logic [3:0]  addr_pins;
    logic [3:0]  data_pins;

    int checks = 0;
    int errors = 0;
    logic [15:0] wd [4];

    ram_pin_link #(
        .RAM_PINS (4),
        .ADDR_BITS(16),
        .DATA_BITS(16),
        .LATENCY  (3),
        .LEN_BITS (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_len  (req_len),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_last (rsp_last),
        .addr_pins(addr_pins),
        .data_pins(data_pins)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n, input string name);
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 16'h0000;
        req_len   = 2'd0;
        data_pins = 4'h0;
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("%s_ap%0d", name, i), 32'(addr_pins), 32'h0);
            chk($sformatf("%s_rdy%0d", name, i), 32'(req_ready), 32'h1);
            chk($sformatf("%s_rv%0d", name, i), 32'(rsp_valid), 32'h0);
            chk($sformatf("%s_rl%0d", name, i), 32'(rsp_last), 32'h0);
        end
        reset = 1'b0;
    endtask

    // Cycle 0 is the acceptance cycle; inputs are driven and outputs checked
    // at the start of each cycle, one time unit after the rising edge.
    task automatic run_txn(input logic [15:0] a, input logic [1:0] l, input bit hold2,
                           input int rst_cyc, input bit mutate, input string name);
        int   last;
        int   ncyc;
        int   k;
        bit   aborted;
        logic [3:0]  exp_ap;
        logic        exp_rdy;
        logic        exp_rv;
        logic [15:0] second;
        second = 16'hABCD;
        last   = 12 + 4 * int'(l);
        ncyc   = last + (hold2 ? 7 : 3);
        for (int c = 0; c < ncyc; c++) begin
            reset = (c == rst_cyc) ? 1'b1 : 1'b0;
            if (c == 0) begin
                req_valid = 1'b1;
                req_addr  = a;
                req_len   = l;
            end else if (hold2) begin
                req_valid = 1'b1;
                req_addr  = second;
                req_len   = 2'd0;
            end else begin
                req_valid = 1'b0;
                req_addr  = mutate ? ~a : a;
                req_len   = mutate ? ~l : l;
            end
            if (c >= 8 && c < last) begin
                k = (c - 8) / 4;
                data_pins = wd[k][((c - 8) % 4) * 4 +: 4];
            end else begin
                data_pins = 4'h0;
            end

            aborted = (rst_cyc >= 0) && (c > rst_cyc);
            if (aborted) begin
                exp_ap = 4'h0;
            end else if (c == 1) begin
                exp_ap = 4'hF;
            end else if (c >= 2 && c <= 5) begin
                exp_ap = a[(c - 2) * 4 +: 4];
            end else if (hold2 && c == last + 1) begin
                exp_ap = 4'hF;
            end else if (hold2 && c >= last + 2 && c <= last + 5) begin
                exp_ap = second[(c - last - 2) * 4 +: 4];
            end else begin
                exp_ap = 4'h0;
            end
            if (aborted || c == 0 || c == last) begin
                exp_rdy = 1'b1;
            end else begin
                exp_rdy = (c > last && !hold2) ? 1'b1 : 1'b0;
            end
            exp_rv = !aborted && c >= 12 && c <= last && ((c - 12) % 4 == 0);

            chk($sformatf("%s_ap_c%0d", name, c), 32'(addr_pins), 32'(exp_ap));
            chk($sformatf("%s_rdy_c%0d", name, c), 32'(req_ready), 32'(exp_rdy));
            chk($sformatf("%s_rv_c%0d", name, c), 32'(rsp_valid), 32'(exp_rv));
            chk($sformatf("%s_rl_c%0d", name, c), 32'(rsp_last), 32'(exp_rv && c == last));
            if (exp_rv) begin
                chk($sformatf("%s_rd_c%0d", name, c), 32'(rsp_data), 32'(wd[(c - 12) / 4]));
            end
            if (!aborted && !hold2 && c == last + 1) begin
                chk($sformatf("%s_hold_c%0d", name, c), 32'(rsp_data), 32'(wd[int'(l)]));
            end
            step();
        end
        reset     = 1'b0;
        req_valid = 1'b0;
        data_pins = 4'h0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 16'h0000;
        req_len   = 2'd0;
        data_pins = 4'h0;

        do_reset(2, "reset");

        wd[0] = 16'hBEEF; wd[1] = 16'h0000; wd[2] = 16'h0000; wd[3] = 16'h0000;
        run_txn(16'h1234, 2'd0, 1'b0, -1, 1'b0, "single");

        wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333; wd[3] = 16'h0000;
        run_txn(16'h0100, 2'd2, 1'b0, -1, 1'b1, "burst3_mut");

        wd[0] = 16'hA5C3; wd[1] = 16'h5A3C; wd[2] = 16'h0F0F; wd[3] = 16'hF00D;
        run_txn(16'hFFFF, 2'd3, 1'b0, -1, 1'b1, "burst4_max");

        wd[0] = 16'hBEEF; wd[1] = 16'h0000; wd[2] = 16'h0000; wd[3] = 16'h0000;
        run_txn(16'h1234, 2'd0, 1'b0, 9, 1'b0, "abort");

        run_txn(16'h1234, 2'd0, 1'b1, -1, 1'b0, "b2b");
        do_reset(1, "reset_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
